// File: rtl/drp_pkg.sv
// Shared definitions for the DRP command sequencer: data width, full-mask
// constant, FSM state type and the read-modify-write merge helper.
package drp_pkg;

  localparam int unsigned DRP_DW = 16;
  localparam logic [DRP_DW-1:0] DRP_MASK_ALL = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RESP
  } drp_state_t;

  // Bits set in mask take the new data, the rest keep the old register value.
  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] old_val,
                                                  input logic [DRP_DW-1:0] new_val,
                                                  input logic [DRP_DW-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/drp_wait_timer.sv
// Wait counter for DRP accesses. Zeroed by clear, counts while en is high and
// holds once it reaches TIMEOUT_CYCLES-1, where expired is raised.
module drp_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturating cycle counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/drp_cmd_sequencer.sv
// DRP bus master: takes read / write / masked-write commands and runs them as
// one or two DRP transactions, returning a one-cycle response.
// Optional access timeout: define DRP_CMD_TIMEOUT_EN.
module drp_cmd_sequencer
  import drp_pkg::*;
#(
  parameter int unsigned DRP_ABITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 drp_clk,
  input  logic                 drp_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [DRP_ABITS-1:0] cmd_addr,
  input  logic [DRP_DW-1:0]    cmd_data,
  input  logic [DRP_DW-1:0]    cmd_mask,
  output logic                 rsp_valid,
  output logic [DRP_DW-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 drp_en,
  output logic                 drp_we,
  output logic [DRP_ABITS-1:0] drp_addr,
  output logic [DRP_DW-1:0]    drp_di,
  input  logic                 drp_rdy,
  input  logic [DRP_DW-1:0]    drp_do
);

  if (TIMEOUT_CYCLES < 4) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  drp_state_t state, next_state;

  logic                 rmw_q;
  logic [DRP_DW-1:0]    data_q;
  logic [DRP_DW-1:0]    mask_q;
  logic [DRP_DW-1:0]    old_q;
  logic                 accept;
  logic                 timed_out;
  logic                 capture_old;
  logic                 next_err;
  logic [DRP_ABITS-1:0] next_addr;
  logic [DRP_DW-1:0]    next_di;
  logic [DRP_DW-1:0]    next_rsp_data;

  assign accept = cmd_valid && cmd_ready;

`ifdef DRP_CMD_TIMEOUT_EN
  logic timer_clear;
  logic timer_en;

  // Counter reads 0 during the drp_en cycle, so expiry lands TIMEOUT_CYCLES-1 cycles later.
  assign timer_clear = (next_state == ST_RD_ISSUE) || (next_state == ST_WR_ISSUE);
  assign timer_en    = (state != ST_IDLE) && (state != ST_RESP);

  drp_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (drp_clk),
    .rst_n  (drp_rst_n),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge drp_clk) begin
    if (!drp_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the values the output registers load with it.
  always_comb begin
    next_state    = state;
    next_addr     = drp_addr;
    next_di       = drp_di;
    next_rsp_data = '0;
    next_err      = 1'b0;
    capture_old   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          next_addr = cmd_addr;
          if (cmd_we && (cmd_mask == DRP_MASK_ALL)) begin
            next_state = ST_WR_ISSUE;
            next_di    = cmd_data;
          end else begin
            next_state = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE, ST_RD_WAIT: begin
        if (drp_rdy) begin
          capture_old = 1'b1;
          if (rmw_q) begin
            next_state = ST_WR_ISSUE;
            next_di    = drp_merge(drp_do, data_q, mask_q);
          end else begin
            next_state    = ST_RESP;
            next_rsp_data = drp_do;
          end
        end else if (timed_out && (state == ST_RD_WAIT)) begin
          next_state = ST_RESP;
          next_err   = 1'b1;
        end else begin
          next_state = ST_RD_WAIT;
        end
      end
      ST_WR_ISSUE, ST_WR_WAIT: begin
        if (drp_rdy) begin
          next_state    = ST_RESP;
          next_rsp_data = rmw_q ? old_q : '0;
        end else if (timed_out && (state == ST_WR_WAIT)) begin
          next_state = ST_RESP;
          next_err   = 1'b1;
        end else begin
          next_state = ST_WR_WAIT;
        end
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Command capture and registered outputs, decoded from the next state.
  always_ff @(posedge drp_clk) begin
    if (!drp_rst_n) begin
      rmw_q     <= 1'b0;
      data_q    <= '0;
      mask_q    <= '0;
      old_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      drp_en    <= 1'b0;
      drp_we    <= 1'b0;
      drp_addr  <= '0;
      drp_di    <= '0;
    end else begin
      if (accept) begin
        rmw_q  <= cmd_we && (cmd_mask != DRP_MASK_ALL);
        data_q <= cmd_data;
        mask_q <= cmd_mask;
      end
      if (capture_old) begin
        old_q <= drp_do;
      end
      cmd_ready <= (next_state == ST_IDLE);
      drp_en    <= (next_state == ST_RD_ISSUE) || (next_state == ST_WR_ISSUE);
      drp_we    <= (next_state == ST_WR_ISSUE);
      drp_addr  <= next_addr;
      drp_di    <= next_di;
      rsp_valid <= (next_state == ST_RESP);
      rsp_data  <= next_rsp_data;
      rsp_err   <= next_err;
    end
  end

endmodule

// File: tb/tb_drp_cmd_sequencer.sv
// Self-checking bench for drp_cmd_sequencer with a DRP slave model
// (write ready 2 cycles after drp_en, read ready 3 cycles after, registers 8..11).
module tb_drp_cmd_sequencer;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          drp_clk;
  logic          drp_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_data;
  logic [15:0]   cmd_mask;
  logic          rsp_valid;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          drp_en;
  logic          drp_we;
  logic [AW-1:0] drp_addr;
  logic [15:0]   drp_di;
  logic          drp_rdy;
  logic [15:0]   drp_do;

  int total = 0;
  int bad   = 0;

  int rd_lat = 3;
  int wr_lat = 2;
  bit slave_silent = 0;
  bit stray_req = 0;

  logic [15:0] slv_mem [8:11];
  logic [15:0] ref_mem [8:11];

  drp_cmd_sequencer #(
    .DRP_ABITS(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .drp_clk  (drp_clk),
    .drp_rst_n(drp_rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_mask (cmd_mask),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .drp_en   (drp_en),
    .drp_we   (drp_we),
    .drp_addr (drp_addr),
    .drp_di   (drp_di),
    .drp_rdy  (drp_rdy),
    .drp_do   (drp_do)
  );

  initial drp_clk = 1'b0;
  always #5 drp_clk = ~drp_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Slave model, evaluated on the falling edge.
  initial begin
    int          cnt;
    logic [7:0]  a;
    logic        w;
    logic [15:0] di;
    cnt = 0; a = '0; w = 1'b0; di = '0;
    drp_rdy = 1'b0;
    drp_do  = '0;
    forever begin
      @(negedge drp_clk);
      drp_rdy = 1'b0;
      drp_do  = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_rdy = 1'b1;
          if (a >= 8 && a <= 11) begin
            if (w) slv_mem[a] = di;
            else   drp_do = slv_mem[a];
          end else begin
            drp_do = 16'hDEAD;
          end
        end
      end
      if (stray_req) begin
        drp_rdy   = 1'b1;
        drp_do    = 16'hBEEF;
        stray_req = 1'b0;
      end
      if (drp_en && !slave_silent) begin
        cnt = drp_we ? wr_lat : rd_lat;
        a   = drp_addr;
        w   = drp_we;
        di  = drp_di;
      end
    end
  end

  // Reference model: expected response, transaction counts, write value and
  // accept-to-response latency; updates ref_mem.
  function automatic void model(input logic we, input logic [7:0] a,
                                input logic [15:0] d, input logic [15:0] m,
                                output logic [15:0] rsp, output int ens,
                                output int wes, output int cyc,
                                output logic [15:0] wdata);
    logic [15:0] old;
    old = ref_mem[a];
    wdata = '0;
    if (!we) begin
      rsp = old; ens = 1; wes = 0; cyc = 1 + (rd_lat + 1);
    end else if (m == 16'hFFFF) begin
      rsp = '0; ens = 1; wes = 1; wdata = d; cyc = 1 + (wr_lat + 1);
      ref_mem[a] = d;
    end else begin
      for (int i = 0; i < 16; i++) wdata[i] = m[i] ? d[i] : old[i];
      rsp = old; ens = 2; wes = 1; cyc = 1 + (rd_lat + 1) + (wr_lat + 1);
      ref_mem[a] = wdata;
    end
  endfunction

  // Runs one command from a falling edge; returns what was observed.
  task automatic do_cmd(input logic we, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] m, output logic [15:0] rd, output logic er,
                        output int ens, output int wes, output int cyc,
                        output logic [15:0] wdata, output logic [2:0] proto);
    bit got, rdy_ok, stable_ok;
    rd = '0; er = 1'b0; ens = 0; wes = 0; cyc = 0; wdata = '0;
    got = 0; rdy_ok = 1; stable_ok = 1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d; cmd_mask = m;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge drp_clk);
    if (cmd_ready) begin
      @(negedge drp_clk);
      cmd_we = 1'($urandom); cmd_addr = 8'($urandom_range(8, 11));
      cmd_data = 16'($urandom); cmd_mask = 16'($urandom);
      for (int c = 1; c <= 400; c++) begin
        if (rsp_valid) begin
          rd = rsp_data; er = rsp_err; cyc = c; got = 1;
          cmd_valid = 1'b0;
          break;
        end
        if (cmd_ready) rdy_ok = 0;
        if (drp_addr !== a) stable_ok = 0;
        if (wes > 0 && drp_di !== wdata) stable_ok = 0;
        if (drp_en) ens++;
        if (drp_en && drp_we) begin wes++; wdata = drp_di; end
        @(negedge drp_clk);
      end
      cmd_valid = 1'b0;
      if (got) begin
        @(negedge drp_clk);
        if (!cmd_ready || rsp_valid) rdy_ok = 0;
      end
    end
    cmd_valid = 1'b0;
    proto = {got, rdy_ok, stable_ok};
  endtask

  task automatic pulse_stray();
    stray_req = 1'b1;
    for (int i = 0; i < 4 && stray_req; i++) @(negedge drp_clk);
  endtask

  task automatic test_reset();
    drp_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    repeat (3) @(negedge drp_clk);
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b rv=%b rd=%h err=%b en=%b we=%b addr=%h di=%h exp all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di);
    end
    drp_rst_n = 1'b1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_release got=%b exp=0", cmd_ready); end
    @(negedge drp_clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd, wd, e_rd, e_wd; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    model(1'b1, 8'd8, 16'h1234, 16'hFFFF, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b1, 8'd8, 16'h1234, 16'hFFFF, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, 16'h0000}) begin bad++;
      $display("FAIL wr_rsp got proto=%b err=%b data=%h exp proto=111 err=0 data=0000", pr, er, rd); end
    total++;
    if (ens !== 1 || wes !== 1 || wd !== 16'h1234 || cyc !== e_cyc) begin bad++;
      $display("FAIL wr_bus got en=%0d we=%0d di=%h cyc=%0d exp en=1 we=1 di=1234 cyc=%0d", ens, wes, wd, cyc, e_cyc); end
    model(1'b0, 8'd8, 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b0, 8'd8, 16'h5A5A, 16'h0F0F, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, 16'h1234}) begin bad++;
      $display("FAIL rd_after_wr got proto=%b err=%b data=%h exp proto=111 err=0 data=1234", pr, er, rd); end
    total++;
    if (ens !== 1 || wes !== 0 || cyc !== e_cyc) begin bad++;
      $display("FAIL rd_bus got en=%0d we=%0d cyc=%0d exp en=1 we=0 cyc=%0d", ens, wes, cyc, e_cyc); end
  endtask

  task automatic test_rmw();
    logic [15:0] rd, wd, e_rd, e_wd; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    model(1'b1, 8'd9, 16'h1234, 16'hFFFF, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b1, 8'd9, 16'h1234, 16'hFFFF, rd, er, ens, wes, cyc, wd, pr);
    model(1'b1, 8'd9, 16'hAB55, 16'h00FF, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b1, 8'd9, 16'hAB55, 16'h00FF, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, 16'h1234}) begin bad++;
      $display("FAIL rmw_rsp got proto=%b err=%b data=%h exp proto=111 err=0 data=1234", pr, er, rd); end
    total++;
    if (ens !== 2 || wes !== 1 || wd !== 16'h1255 || cyc !== e_cyc) begin bad++;
      $display("FAIL rmw_bus got en=%0d we=%0d di=%h cyc=%0d exp en=2 we=1 di=1255 cyc=%0d", ens, wes, wd, cyc, e_cyc); end
    model(1'b0, 8'd9, 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b0, 8'd9, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, 16'h1255}) begin bad++;
      $display("FAIL rmw_readback got proto=%b err=%b data=%h exp proto=111 err=0 data=1255", pr, er, rd); end
  endtask

  task automatic test_random_cmds();
    logic [15:0] rd, wd, e_rd, e_wd, d, m; logic er, we; logic [7:0] a;
    int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom);
      a  = 8'($urandom_range(8, 11));
      d  = 16'($urandom);
      m  = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      model(we, a, d, m, e_rd, e_ens, e_wes, e_cyc, e_wd);
      do_cmd(we, a, d, m, rd, er, ens, wes, cyc, wd, pr);
      total++;
      if ({pr, er, rd} !== {3'b111, 1'b0, e_rd}) begin bad++;
        $display("FAIL rand_rsp[%0d] got proto=%b err=%b data=%h exp proto=111 err=0 data=%h", n, pr, er, rd, e_rd); end
      total++;
      if (ens !== e_ens || wes !== e_wes || cyc !== e_cyc) begin bad++;
        $display("FAIL rand_bus[%0d] got en=%0d we=%0d cyc=%0d exp en=%0d we=%0d cyc=%0d",
                 n, ens, wes, cyc, e_ens, e_wes, e_cyc); end
      total++;
      if (wd !== e_wd) begin bad++;
        $display("FAIL rand_wdata[%0d] got=%h exp=%h", n, wd, e_wd); end
    end
  endtask

  task automatic test_back_to_back();
    logic        we [4];
    logic [7:0]  a  [4];
    logic [15:0] d  [4];
    logic [15:0] m  [4];
    logic [15:0] e_rd [4];
    int          e_gap [4];
    logic [15:0] e_wd;
    int e_ens_tot, e1, e2, acc, rsp_n, ens, last_acc, proto_bad;
    bit load;
    e_ens_tot = 0;
    for (int i = 0; i < 4; i++) begin
      we[i] = (i != 0);
      a[i]  = 8'(8 + i);
      d[i]  = 16'($urandom);
      m[i]  = (i == 2) ? 16'($urandom_range(1, 16'hFFFE)) : 16'hFFFF;
      model(we[i], a[i], d[i], m[i], e_rd[i], e1, e2, e_gap[i], e_wd);
      e_gap[i] = e_gap[i] + 1;
      e_ens_tot += e1;
    end
    acc = 0; rsp_n = 0; ens = 0; last_acc = 0; proto_bad = 0;
    cmd_valid = 1'b1; cmd_we = we[0]; cmd_addr = a[0]; cmd_data = d[0]; cmd_mask = m[0];
    for (int c = 0; c < 300 && rsp_n < 4; c++) begin
      load = 0;
      if (rsp_valid) begin
        total++;
        if ({rsp_err, rsp_data} !== {1'b0, e_rd[rsp_n]}) begin bad++;
          $display("FAIL b2b_rsp[%0d] got err=%b data=%h exp err=0 data=%h", rsp_n, rsp_err, rsp_data, e_rd[rsp_n]); end
        rsp_n++;
      end
      if (cmd_ready && acc != rsp_n) proto_bad++;
      if (drp_en) ens++;
      if (cmd_valid && cmd_ready) begin
        if (acc > 0) begin
          total++;
          if (c - last_acc !== e_gap[acc-1]) begin bad++;
            $display("FAIL b2b_period[%0d] got=%0d exp=%0d", acc - 1, c - last_acc, e_gap[acc-1]); end
        end
        last_acc = c;
        acc++;
        load = 1;
      end
      @(negedge drp_clk);
      if (load) begin
        if (acc < 4) begin
          cmd_we = we[acc]; cmd_addr = a[acc]; cmd_data = d[acc]; cmd_mask = m[acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (acc !== 4 || rsp_n !== 4 || ens !== e_ens_tot || proto_bad !== 0) begin bad++;
      $display("FAIL b2b_counts got acc=%0d rsp=%0d en=%0d ready_viol=%0d exp acc=4 rsp=4 en=%0d ready_viol=0",
               acc, rsp_n, ens, proto_bad, e_ens_tot); end
    @(negedge drp_clk);
  endtask

`ifdef DRP_CMD_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] rd, wd, e_rd, e_wd, keep; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc, n; logic [2:0] pr;
    slave_silent = 1;
    do_cmd(1'b0, 8'd10, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b1, 16'h0000} || ens !== 1 || cyc !== 1 + TO) begin bad++;
      $display("FAIL to_read got proto=%b err=%b data=%h en=%0d cyc=%0d exp proto=111 err=1 data=0000 en=1 cyc=%0d",
               pr, er, rd, ens, cyc, 1 + TO); end
    n = 0;
    pulse_stray();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || drp_en || !cmd_ready) n++;
      @(negedge drp_clk);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL to_late_rdy got activity=%0d exp=0", n); end
    keep = ref_mem[11];
    do_cmd(1'b1, 8'd11, 16'hFFFF, 16'h0F00, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b1, 16'h0000} || ens !== 1 || wes !== 0) begin bad++;
      $display("FAIL to_rmw got proto=%b err=%b data=%h en=%0d we=%0d exp proto=111 err=1 data=0000 en=1 we=0",
               pr, er, rd, ens, wes); end
    slave_silent = 0;
    model(1'b0, 8'd11, 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b0, 8'd11, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, keep}) begin bad++;
      $display("FAIL to_recover got proto=%b err=%b data=%h exp proto=111 err=0 data=%h", pr, er, rd, keep); end
    rd_lat = TO - 1;
    model(1'b0, 8'd10, 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b0, 8'd10, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, e_rd} || cyc !== e_cyc) begin bad++;
      $display("FAIL to_rdy_wins got proto=%b err=%b data=%h cyc=%0d exp proto=111 err=0 data=%h cyc=%0d",
               pr, er, rd, cyc, e_rd, e_cyc); end
    rd_lat = TO;
    do_cmd(1'b0, 8'd10, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b1, 16'h0000} || cyc !== 1 + TO) begin bad++;
      $display("FAIL to_rdy_late got proto=%b err=%b data=%h cyc=%0d exp proto=111 err=1 data=0000 cyc=%0d",
               pr, er, rd, cyc, 1 + TO); end
    rd_lat = 3;
    repeat (3) @(negedge drp_clk);
  endtask
`else
  task automatic test_no_timeout();
    int n; bit got; logic [15:0] rd; logic er;
    slave_silent = 1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'd10; cmd_data = '0; cmd_mask = '0;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge drp_clk);
    @(negedge drp_clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 4 * TO; i++) begin
      if (rsp_valid) n++;
      @(negedge drp_clk);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL notimeout_wait got rsp=%0d exp=0", n); end
    pulse_stray();
    got = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rsp_valid) begin got = 1; rd = rsp_data; er = rsp_err; end
      else @(negedge drp_clk);
    end
    total++;
    if ({got, er, rd} !== {1'b1, 1'b0, 16'hBEEF}) begin bad++;
      $display("FAIL notimeout_done got rsp=%b err=%b data=%h exp rsp=1 err=0 data=beef", got, er, rd); end
    slave_silent = 0;
    repeat (2) @(negedge drp_clk);
  endtask
`endif

  task automatic test_reset_mid();
    int n; logic [15:0] rd, wd, e_rd, e_wd; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'd10; cmd_data = '0; cmd_mask = '0;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge drp_clk);
    @(negedge drp_clk);
    cmd_valid = 1'b0;
    @(negedge drp_clk);
    drp_rst_n = 1'b0;
    @(negedge drp_clk);
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got rdy=%b rv=%b rd=%h err=%b en=%b we=%b addr=%h di=%h exp all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, drp_en, drp_we, drp_addr, drp_di);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || drp_en || cmd_ready) n++;
      @(negedge drp_clk);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL midrst_quiet got activity=%0d exp=0", n); end
    drp_rst_n = 1'b1;
    @(negedge drp_clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
    n = 0;
    pulse_stray();
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || drp_en || !cmd_ready) n++;
      @(negedge drp_clk);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL midrst_stray got activity=%0d exp=0", n); end
    model(1'b0, 8'd10, 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b0, 8'd10, 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, e_rd} || cyc !== e_cyc) begin bad++;
      $display("FAIL midrst_next got proto=%b err=%b data=%h cyc=%0d exp proto=111 err=0 data=%h cyc=%0d",
               pr, er, rd, cyc, e_rd, e_cyc); end
  endtask

  task automatic test_idle_rdy();
    int n; logic [15:0] rd, wd, e_rd, e_wd; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    n = 0;
    pulse_stray();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || drp_en || !cmd_ready) n++;
      @(negedge drp_clk);
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL idle_rdy got activity=%0d exp=0", n); end
    model(1'b1, 8'd8, 16'hC3C3, 16'h3C00, e_rd, e_ens, e_wes, e_cyc, e_wd);
    do_cmd(1'b1, 8'd8, 16'hC3C3, 16'h3C00, rd, er, ens, wes, cyc, wd, pr);
    total++;
    if ({pr, er, rd} !== {3'b111, 1'b0, e_rd} || wd !== e_wd || cyc !== e_cyc) begin bad++;
      $display("FAIL idle_next got proto=%b err=%b data=%h di=%h cyc=%0d exp proto=111 err=0 data=%h di=%h cyc=%0d",
               pr, er, rd, wd, cyc, e_rd, e_wd, e_cyc); end
  endtask

  task automatic test_readback();
    logic [15:0] rd, wd, e_rd, e_wd; logic er; int ens, wes, cyc, e_ens, e_wes, e_cyc; logic [2:0] pr;
    for (int r = 8; r <= 11; r++) begin
      model(1'b0, 8'(r), 16'h0, 16'h0, e_rd, e_ens, e_wes, e_cyc, e_wd);
      do_cmd(1'b0, 8'(r), 16'h0, 16'h0, rd, er, ens, wes, cyc, wd, pr);
      total++;
      if ({pr, er, rd} !== {3'b111, 1'b0, e_rd}) begin bad++;
        $display("FAIL readback[%0d] got proto=%b err=%b data=%h exp proto=111 err=0 data=%h", r, pr, er, rd, e_rd); end
    end
  endtask

  initial begin
    for (int r = 8; r <= 11; r++) begin
      slv_mem[r] = 16'($urandom);
      ref_mem[r] = slv_mem[r];
    end
    drp_rst_n = 1'b0;
    cmd_valid = 1'b0;
    @(negedge drp_clk);
    test_reset();
    test_write_read();
    test_rmw();
    test_random_cmds();
    test_back_to_back();
`ifdef DRP_CMD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    test_idle_rdy();
    test_readback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
